// File: rtl/sequence_player.sv
// Replays a stored colour sequence from the circular sequence RAM onto one-hot LEDs.
// Each entry costs one fetch, one wait, ON_CYCLES lit and OFF_CYCLES dark clocks.
module sequence_player #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 2,
    parameter int unsigned ON_CYCLES  = 4,
    parameter int unsigned OFF_CYCLES = 2,
    parameter int unsigned MAX_LEN    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] seq_len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [3:0]        led,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LEN_W   = ADDR_W + 1;
    localparam int unsigned CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD  = CNT_W'(OFF_CYCLES - 1);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StShow, StGap, StDone} state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   colour_q, colour_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [3:0]          led_q, led_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [LEN_W-1:0]    req_len;
    logic [LEN_W-1:0]    idx_inc;

    assign req_len = ({1'b0, seq_len} > MAX_LEN_L) ? MAX_LEN_L : {1'b0, seq_len};
    assign idx_inc = idx_q + LEN_W'(1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        base_d   = base_q;
        colour_d = colour_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = base_addr;
                    len_d   = req_len;
                    idx_d   = '0;
                    state_d = (req_len == '0) ? StDone : StFetch;
                end
            end
            StFetch: state_d = StWait;
            StWait: begin
                colour_d = rd_data;
                cnt_d    = ON_LOAD;
                state_d  = StShow;
            end
            StShow: begin
                if (cnt_q == '0) begin
                    cnt_d   = OFF_LOAD;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    idx_d   = idx_inc;
                    state_d = (idx_inc == len_q) ? StDone : StFetch;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end

        // Outputs are decoded from the next state so they appear registered with it.
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
        rd_en_d   = (state_d == StFetch);
        rd_addr_d = rd_en_d ? (base_d + idx_d[ADDR_W-1:0]) : rd_addr_q;
        led_d     = (state_d == StShow) ? (4'(1) << colour_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            len_q     <= '0;
            base_q    <= '0;
            colour_q  <= '0;
            cnt_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            led_q     <= 4'b0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            base_q    <= base_d;
            colour_q  <= colour_d;
            cnt_q     <= cnt_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign led     = led_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player: per-cycle scoreboard built from the playback timing rules,
// plus directed scenarios with hand-computed literal expectations.
module tb_sequence_player;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [4:0] base_addr;
    logic [4:0] seq_len;
    logic       rd_en;
    logic [4:0] rd_addr;
    logic [1:0] rd_data = 2'd0;
    logic [3:0] led;
    logic       busy;
    logic       done;

    logic [1:0] mem [32];

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       rd_en;
        logic [4:0] addr;
        logic [3:0] led;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    logic model_idle = 1'b1;

    logic [4:0] addr_log[$];
    logic [3:0] led_log[$];
    logic       busy_log[$];
    int         done_at;

    sequence_player #(
        .ADDR_W(5), .DATA_W(2), .ON_CYCLES(4), .OFF_CYCLES(2), .MAX_LEN(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .seq_len(seq_len),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .led(led), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Sequence RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Expected per-cycle outputs for a whole playback, starting the cycle after start.
    task automatic model_play(input logic [4:0] b, input logic [4:0] l);
        int   n;
        logic [4:0] a;
        n = (l > 5'd16) ? 16 : int'(l);
        for (int i = 0; i < n; i++) begin
            a = b + 5'(i);
            exp_q.push_back('{rd_en: 1'b1, addr: a, led: 4'b0, busy: 1'b1, done: 1'b0});
            exp_q.push_back('{rd_en: 1'b0, addr: 5'd0, led: 4'b0, busy: 1'b1, done: 1'b0});
            for (int j = 0; j < 4; j++)
                exp_q.push_back('{rd_en: 1'b0, addr: 5'd0, led: 4'(1) << mem[a],
                                  busy: 1'b1, done: 1'b0});
            for (int j = 0; j < 2; j++)
                exp_q.push_back('{rd_en: 1'b0, addr: 5'd0, led: 4'b0, busy: 1'b1, done: 1'b0});
        end
        exp_q.push_back('{rd_en: 1'b0, addr: 5'd0, led: 4'b0, busy: 1'b1, done: 1'b1});
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
        end else if (model_idle && start) begin
            model_play(base_addr, seq_len);
        end else if (!model_idle && abort) begin
            exp_q.delete();
        end
    end

    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            model_idle = 1'b0;
        end else begin
            e = '0;
            model_idle = 1'b1;
        end
        g = {rd_en, (rd_en ? rd_addr : 5'd0), led, busy, done};
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL cycle@%0t: got rd_en=%b addr=%0d led=%b busy=%b done=%b expected rd_en=%b addr=%0d led=%b busy=%b done=%b",
                     $time, g.rd_en, g.addr, g.led, g.busy, g.done,
                     e.rd_en, e.addr, e.led, e.busy, e.done);
        end
    end

    // Start a playback and log outputs from cycle 1 until done or the budget runs out.
    task automatic play(input logic [4:0] b, input logic [4:0] l, input int budget,
                        input int inj_cyc, input int abt_cyc);
        addr_log.delete();
        led_log.delete();
        busy_log.delete();
        done_at = 0;
        @(negedge clk);
        base_addr = b;
        seq_len   = l;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            if (k > 1) @(negedge clk);
            if (rd_en) addr_log.push_back(rd_addr);
            led_log.push_back(led);
            busy_log.push_back(busy);
            if (inj_cyc != 0 && k == inj_cyc) begin
                base_addr = 5'd10;
                seq_len   = 5'd5;
                start     = 1'b1;
            end
            if (inj_cyc != 0 && k == inj_cyc + 1) start = 1'b0;
            if (abt_cyc != 0 && k == abt_cyc) abort = 1'b1;
            if (abt_cyc != 0 && k == abt_cyc + 1) abort = 1'b0;
            if (done) begin
                done_at = k;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    function automatic int lit_count();
        int c = 0;
        foreach (led_log[i]) if (led_log[i] != 4'b0) c++;
        return c;
    endfunction

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = 5'd0;
        seq_len   = 5'd0;
        for (int i = 0; i < 32; i++) mem[i] = 2'd0;
        #1;
        check("reset_rd_en", int'(rd_en), 0);
        check("reset_rd_addr", int'(rd_addr), 0);
        check("reset_led", int'(led), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Basic playback
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
        play(5'd0, 5'd3, 40, 0, 0);
        check("basic_done_at", done_at, 25);
        check("basic_n_rd", addr_log.size(), 3);
        if (addr_log.size() == 3) begin
            check("basic_addr0", int'(addr_log[0]), 0);
            check("basic_addr1", int'(addr_log[1]), 1);
            check("basic_addr2", int'(addr_log[2]), 2);
        end
        if (led_log.size() >= 25) begin
            check("basic_led_c3", int'(led_log[2]), 4);
            check("basic_led_c7", int'(led_log[6]), 0);
            check("basic_led_c11", int'(led_log[10]), 1);
            check("basic_led_c19", int'(led_log[18]), 8);
        end
        check("basic_lit_cycles", lit_count(), 12);

        // Wrap-around
        mem[30] = 2'd1; mem[31] = 2'd1; mem[0] = 2'd2; mem[1] = 2'd3;
        play(5'd30, 5'd4, 50, 0, 0);
        check("wrap_done_at", done_at, 33);
        check("wrap_n_rd", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            check("wrap_addr0", int'(addr_log[0]), 30);
            check("wrap_addr1", int'(addr_log[1]), 31);
            check("wrap_addr2", int'(addr_log[2]), 0);
            check("wrap_addr3", int'(addr_log[3]), 1);
        end
        if (led_log.size() >= 33) begin
            check("wrap_led0", int'(led_log[2]), 2);
            check("wrap_led1", int'(led_log[10]), 2);
            check("wrap_led2", int'(led_log[18]), 4);
            check("wrap_led3", int'(led_log[26]), 8);
        end

        // Zero length and clamp
        play(5'd0, 5'd0, 10, 0, 0);
        check("zero_done_at", done_at, 1);
        check("zero_n_rd", addr_log.size(), 0);
        for (int i = 0; i < 32; i++) mem[i] = 2'(i % 4);
        play(5'd0, 5'd20, 200, 0, 0);
        check("clamp_n_rd", addr_log.size(), 16);
        check("clamp_done_at", done_at, 129);

        // Abort during second SHOW, then a fresh replay
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
        play(5'd0, 5'd3, 20, 0, 12);
        check("abort_no_done", done_at, 0);
        if (busy_log.size() >= 13) begin
            check("abort_led_c12", int'(led_log[11]), 1);
            check("abort_busy_c13", int'(busy_log[12]), 0);
            check("abort_led_c13", int'(led_log[12]), 0);
        end
        play(5'd0, 5'd3, 40, 0, 0);
        check("replay_done_at", done_at, 25);
        if (addr_log.size() > 0) check("replay_addr0", int'(addr_log[0]), 0);
        check("replay_led_c3", int'(led_log[2]), 4);

        // Start while busy is ignored
        play(5'd0, 5'd3, 40, 5, 0);
        check("busy_start_done_at", done_at, 25);
        check("busy_start_n_rd", addr_log.size(), 3);
        if (addr_log.size() == 3) check("busy_start_addr2", int'(addr_log[2]), 2);

        // Asynchronous reset mid-GAP
        play(5'd0, 5'd3, 7, 0, 0);
        check("pre_reset_busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_led", int'(led), 0);
        check("async_reset_rd_en", int'(rd_en), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        play(5'd0, 5'd3, 40, 0, 0);
        check("post_reset_done_at", done_at, 25);
        check("post_reset_lit_cycles", lit_count(), 12);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
